// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multicycle multiply/divide unit.
//   muldiv_op_t    : operation encoding presented on the op port.
//   muldiv_state_t : sequencer states (IDLE, RUN, FIX, DONE).
//   neg_if()       : conditional two's-complement negate, used for operand
//                    magnitudes and for the final sign correction.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } muldiv_state_t;

  // neg_if works on a fixed wide vector; callers zero-extend into it and keep
  // the low bits they need. This covers a 2*WIDTH product for WIDTH up to 64.
  localparam int NEG_W = 128;

  function automatic logic [NEG_W-1:0] neg_if(input logic [NEG_W-1:0] value,
                                               input logic             cond);
    return cond ? ((~value) + {{(NEG_W-1){1'b0}}, 1'b1}) : value;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Single-iteration combinational kernel for muldiv_unit.
//   mode_i : current operation; only multiply vs divide matters here.
//   acc_i  : 2*WIDTH accumulator {upper, lower}.
//            multiply: {partial product, remaining multiplier bits}
//            divide  : {partial remainder, remaining dividend / quotient bits}
//   opnd_i : multiplicand or divisor magnitude.
//   acc_o  : accumulator after one iteration.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  muldiv_op_t         mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic           is_div;
  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_diff;

  always_comb begin
    is_div    = (mode_i == OP_DIV) || (mode_i == OP_DIVU);
    // Shift-add: the carry out of the upper half becomes the new top bit.
    add_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
    // Restoring divide: remainder shifted left with the next dividend bit.
    // The remainder stays below the divisor, so WIDTH+1 bits always suffice
    // and the top bit of the difference is a clean borrow flag.
    rem_shift = acc_i[2*WIDTH-1:WIDTH-1];
    rem_diff  = rem_shift - {1'b0, opnd_i};
    if (is_div) begin
      if (rem_diff[WIDTH]) begin
        acc_o = {rem_shift[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {rem_diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end
    end else if (acc_i[0]) begin
      acc_o = {add_sum, acc_i[WIDTH-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle integer multiply/divide unit with its own HI/LO registers.
//   Clk, reset       : rising-edge clock, asynchronous active-low reset.
//   start, op        : launch MULT/MULTU/DIV/DIVU on oper_A, oper_B.
//   hi_we, lo_we     : MTHI/MTLO writes of wdata, honoured only in IDLE.
//   busy, done       : busy while not IDLE; done is a one-cycle result pulse.
//   div_by_zero      : pulses with done when the divisor was zero.
//   hi, lo           : result registers (product {hi,lo}; remainder/quotient).
//   count            : iterations completed in the current operation.
// Handshake: start is accepted only on a cycle where busy=0 (the unit is in
// IDLE); there is no queueing, a start seen while busy is dropped. After
// acceptance busy stays high until and including the single done cycle, and
// hi/lo already hold the result during that done cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] oper_A,
  input  logic [WIDTH-1:0] oper_B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [CNT_W-1:0] count
);

  muldiv_state_t      state_q, state_d;
  muldiv_op_t         op_q, op_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_res_q, neg_res_d;  // quotient / product negative
  logic               neg_rem_q, neg_rem_d;  // remainder follows dividend sign
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  muldiv_op_t         op_in;
  logic               in_signed, in_div, sign_a, sign_b, run_div;
  logic [NEG_W-1:0]   a_ext, b_ext, prod_ext, quo_ext, rem_ext;
  logic [NEG_W-1:0]   mag_a_w, mag_b_w, prod_w, quo_w, rem_w;
  logic [2*WIDTH-1:0] step_acc;
  logic               unused_neg_bits;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_i (op_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  // Operand magnitudes on the way in, sign correction on the way out.
  always_comb begin
    op_in     = muldiv_op_t'(op);
    in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
    run_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    sign_a    = in_signed & oper_A[WIDTH-1];
    sign_b    = in_signed & oper_B[WIDTH-1];
    a_ext     = '0;
    a_ext[WIDTH-1:0] = oper_A;
    b_ext     = '0;
    b_ext[WIDTH-1:0] = oper_B;
    prod_ext  = '0;
    prod_ext[2*WIDTH-1:0] = acc_q;
    quo_ext   = '0;
    quo_ext[WIDTH-1:0] = acc_q[WIDTH-1:0];
    rem_ext   = '0;
    rem_ext[WIDTH-1:0] = acc_q[2*WIDTH-1:WIDTH];
    // MIN negates to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    mag_a_w   = neg_if(a_ext, sign_a);
    mag_b_w   = neg_if(b_ext, sign_b);
    prod_w    = neg_if(prod_ext, neg_res_q);
    quo_w     = neg_if(quo_ext, neg_res_q);
    rem_w     = neg_if(rem_ext, neg_rem_q);
  end

  // Only the low bits of the wide helper results are meaningful.
  assign unused_neg_bits = ^{mag_a_w, mag_b_w, prod_w, quo_w, rem_w};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d  = op_in;
          dbz_d = 1'b0;
          if (in_div && (oper_B == '0)) begin
            // Divide by zero completes immediately; its result wins over a
            // same-cycle MTHI/MTLO write.
            dbz_d   = 1'b1;
            hi_d    = oper_A;
            lo_d    = '1;
            state_d = DONE;
          end else begin
            count_d   = '0;
            acc_d     = {{WIDTH{1'b0}}, mag_a_w[WIDTH-1:0]};
            opnd_d    = mag_b_w[WIDTH-1:0];
            neg_res_d = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        acc_d   = step_acc;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (run_div) begin
          lo_d = quo_w[WIDTH-1:0];
          hi_d = rem_w[WIDTH-1:0];
        end else begin
          {hi_d, lo_d} = prod_w[2*WIDTH-1:0];
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      count_q   <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign div_by_zero = (state_q == DONE) && dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign count       = count_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a WIDTH=32 and a WIDTH=8 instance share the
// clock and reset. Inputs change on the falling edge, outputs are sampled on
// the falling edge. Cycle k is the k-th falling edge after the one that
// raised start.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start32, hi_we32, lo_we32, busy32, done32, dbz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wdata32, hi32, lo32;
  logic [5:0]  count32;

  logic        start8, hi_we8, lo_we8, busy8, done8, dbz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wdata8, hi8, lo8;
  logic [3:0]  count8;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .Clk(clk), .reset(rst_n), .start(start32), .op(op32),
    .oper_A(a32), .oper_B(b32), .hi_we(hi_we32), .lo_we(lo_we32),
    .wdata(wdata32), .busy(busy32), .done(done32), .div_by_zero(dbz32),
    .hi(hi32), .lo(lo32), .count(count32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .reset(rst_n), .start(start8), .op(op8),
    .oper_A(a8), .oper_B(b8), .hi_we(hi_we8), .lo_we(lo_we8),
    .wdata(wdata8), .busy(busy8), .done(done8), .div_by_zero(dbz8),
    .hi(hi8), .lo(lo8), .count(count8)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for done. Returns the done cycle
  // (100 on timeout), whether busy stayed high throughout, and the outputs
  // seen in the done cycle.
  task automatic run_op(input bit use8, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int cyc, output bit busy_ok,
                        output bit dbz, output logic [31:0] h, output logic [31:0] l);
    @(negedge clk);
    if (use8) begin
      start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    end
    cyc = 0; busy_ok = 1'b1; dbz = 1'b0; h = '0; l = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      cyc++;
      start8  = 1'b0;
      start32 = 1'b0;
      if (!(use8 ? busy8 : busy32)) busy_ok = 1'b0;
      if (use8 ? done8 : done32) begin
        dbz = use8 ? dbz8 : dbz32;
        h   = use8 ? {24'h0, hi8} : hi32;
        l   = use8 ? {24'h0, lo8} : lo32;
        break;
      end
    end
  endtask

  task automatic expect_op(input string tag, input bit use8, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b, input int exp_cyc,
                           input bit exp_dbz, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    int          cyc;
    bit          bok, dbz;
    logic [31:0] h, l;
    run_op(use8, op, a, b, cyc, bok, dbz, h, l);
    check({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_busy"}, 32'(bok), 32'd1);
    check({tag, "_dbz"}, 32'(dbz), 32'(exp_dbz));
    check({tag, "_hi"}, h, exp_hi);
    check({tag, "_lo"}, l, exp_lo);
  endtask

  initial begin
    int cyc;
    start32 = 0; op32 = '0; a32 = '0; b32 = '0; hi_we32 = 0; lo_we32 = 0; wdata32 = '0;
    start8  = 0; op8  = '0; a8  = '0; b8  = '0; hi_we8  = 0; lo_we8  = 0; wdata8  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy32), 32'd0);
    check("rst_done", 32'(done32), 32'd0);
    check("rst_dbz", 32'(dbz32), 32'd0);
    check("rst_hi", hi32, 32'd0);
    check("rst_lo", lo32, 32'd0);
    check("rst_count", 32'(count32), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    rst_n = 1'b1;

    // Main arithmetic, WIDTH=32
    expect_op("multu_max", 0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0,
              32'hFFFF_FFFE, 32'h0000_0001);
    check("multu_max_count", 32'(count32), 32'd32);
    @(negedge clk);
    check("idle_busy", 32'(busy32), 32'd0);
    check("idle_done", 32'(done32), 32'd0);
    check("idle_hold_hi", hi32, 32'hFFFF_FFFE);
    expect_op("mult_m3x5", 0, OP_MULT, 32'hFFFF_FFFD, 32'd5, 34, 0,
              32'hFFFF_FFFF, 32'hFFFF_FFF1);
    expect_op("mult_minxmin", 0, OP_MULT, 32'h8000_0000, 32'h8000_0000, 34, 0,
              32'h4000_0000, 32'h0000_0000);
    expect_op("div_m7d2", 0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 0,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);
    expect_op("divu_7d0", 0, OP_DIVU, 32'd7, 32'd0, 1, 1, 32'd7, 32'hFFFF_FFFF);
    expect_op("div_ovf", 0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 0,
              32'h0000_0000, 32'h8000_0000);
    expect_op("divu_100d7", 0, OP_DIVU, 32'd100, 32'd7, 34, 0, 32'd2, 32'd14);
    expect_op("div_7dm2", 0, OP_DIV, 32'd7, 32'hFFFF_FFFE, 34, 0, 32'd1, 32'hFFFF_FFFD);

    // Start and MTHI while busy are ignored; hi holds 1 from the last divide.
    @(negedge clk);
    start32 = 1; op32 = OP_MULTU; a32 = 32'h0001_0000; b32 = 32'h0003_0000;
    cyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      cyc++;
      start32 = (cyc == 5);
      if (cyc == 5) begin op32 = OP_DIVU; a32 = 32'd1; b32 = 32'd0; end
      hi_we32 = (cyc == 10);
      wdata32 = 32'h0000_1234;
      if (cyc == 11) check("busy_hi_we_ignored", hi32, 32'd1);
      if (done32) break;
    end
    check("busy_cycle", 32'(cyc), 32'd34);
    check("busy_dbz", 32'(dbz32), 32'd0);
    check("busy_hi", hi32, 32'd3);
    check("busy_lo", lo32, 32'd0);

    // MTHI / MTLO in IDLE
    @(negedge clk);
    hi_we32 = 1; wdata32 = 32'h0000_1234;
    @(negedge clk);
    hi_we32 = 0;
    check("mthi_hi", hi32, 32'h0000_1234);
    check("mthi_lo", lo32, 32'd0);
    lo_we32 = 1; wdata32 = 32'h0000_5678;
    @(negedge clk);
    lo_we32 = 0;
    check("mtlo_lo", lo32, 32'h0000_5678);
    check("mtlo_hi", hi32, 32'h0000_1234);

    // Asynchronous reset in the middle of a DIVU
    @(negedge clk);
    start32 = 1; op32 = OP_DIVU; a32 = 32'h0000_FFFF; b32 = 32'd3;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start32 = 0;
    end
    check("mid_busy_before", 32'(busy32), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_busy", 32'(busy32), 32'd0);
    check("async_hi", hi32, 32'd0);
    check("async_lo", lo32, 32'd0);
    check("async_count", 32'(count32), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abandon_busy", 32'(busy32), 32'd0);
    check("abandon_lo", lo32, 32'd0);
    expect_op("multu_6x7", 0, OP_MULTU, 32'd6, 32'd7, 34, 0, 32'd0, 32'd42);

    // MTHI in the same cycle as start: write lands, result overwrites later.
    @(negedge clk);
    start32 = 1; op32 = OP_MULTU; a32 = 32'd2; b32 = 32'd3;
    hi_we32 = 1; wdata32 = 32'h0000_ABCD;
    @(negedge clk);
    start32 = 0; hi_we32 = 0;
    check("same_cyc_hi_write", hi32, 32'h0000_ABCD);
    check("same_cyc_busy", 32'(busy32), 32'd1);
    cyc = 1;
    for (int k = 0; k < 100 && !done32; k++) begin
      @(negedge clk);
      cyc++;
    end
    check("same_cyc_cycle", 32'(cyc), 32'd34);
    check("same_cyc_hi", hi32, 32'd0);
    check("same_cyc_lo", lo32, 32'd6);

    // WIDTH=8 instance
    expect_op("w8_multu_max", 1, OP_MULTU, 32'hFF, 32'hFF, 10, 0, 32'hFE, 32'h01);
    expect_op("w8_div_ovf", 1, OP_DIV, 32'h80, 32'hFF, 10, 0, 32'h00, 32'h80);
    expect_op("w8_div_m7d2", 1, OP_DIV, 32'hF9, 32'h02, 10, 0, 32'hFF, 32'hFD);
    expect_op("w8_div_d0", 1, OP_DIV, 32'h85, 32'h00, 1, 1, 32'h85, 32'hFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
